// File: rtl/seq_light_n_if.sv
// Request/step-code bundle between a sequence requester and seq_light_n.
// The master drives requests and timing controls. The slave returns the step code and status.
interface seq_light_n_if #(
   parameter int NCH   = 3,
   parameter int STEPS = 3,
   parameter int DW    = 4
);
   localparam int YW = $clog2(NCH * STEPS + 1);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0] req;
   logic [DW-1:0]  dwell;
   logic           repeat_en;
   logic           abort;
   logic [YW-1:0]  y;
   logic           busy;
   logic [CW-1:0]  active_ch;
   logic           done;

   modport master (
      output req, dwell, repeat_en, abort,
      input  y, busy, active_ch, done
   );

   modport slave (
      input  req, dwell, repeat_en, abort,
      output y, busy, active_ch, done
   );
endinterface

// File: rtl/seq_light_n.sv
// Priority-arbitrated step sequencer. It runs a fixed number of steps for the
// highest requesting channel. Each step is held for dwell+1 cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no sequence running, y=0; samples req each cycle
// S_RUN    | channel ch running step 'step'; cnt counts up to dw_lat
module seq_light_n #(
   parameter int NCH   = 3,
   parameter int STEPS = 3,
   parameter int DW    = 4
) (
   input  logic         clk,
   input  logic         reset,
   seq_light_n_if.slave bus
);
   localparam int YW = $clog2(NCH * STEPS + 1);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] ch;
   logic [SW-1:0] step;
   logic [DW-1:0] cnt;
   logic [DW-1:0] dw_lat;
   logic          done_q;
   logic [CW-1:0] hi_ch;
   logic          enc_ok;
   logic          last_step;

   // Highest set request index wins; later (higher) indices overwrite lower ones.
   always_comb begin
      hi_ch = '0;
      for (int i = 0; i < NCH; i++) begin
         if (bus.req[i]) hi_ch = CW'(i);
      end
   end

   // Step/channel encodings outside the legal range drop the sequencer back to idle.
   always_comb begin
      enc_ok    = (int'(ch) < NCH) && (int'(step) < STEPS);
      last_step = (int'(step) == STEPS - 1);
   end

   // Sequencer state, step timer and completion pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         ch     <= '0;
         step   <= '0;
         cnt    <= '0;
         dw_lat <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.req != '0) begin
                  state  <= S_RUN;
                  ch     <= hi_ch;
                  step   <= '0;
                  cnt    <= '0;
                  dw_lat <= bus.dwell;
               end
            end
            S_RUN: begin
               if (bus.abort || !enc_ok) begin
                  state <= S_IDLE;
                  ch    <= '0;
                  step  <= '0;
                  cnt   <= '0;
               end else if (cnt == dw_lat) begin
                  cnt <= '0;
                  if (last_step) begin
                     done_q <= 1'b1;
                     step   <= '0;
                     // The channel may restart without an idle cycle. It must still be requesting.
                     if (bus.repeat_en && bus.req[ch]) begin
                        dw_lat <= bus.dwell;
                     end else begin
                        state <= S_IDLE;
                        ch    <= '0;
                     end
                  end else begin
                     step <= step + SW'(1);
                  end
               end else begin
                  cnt <= cnt + DW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               ch    <= '0;
               step  <= '0;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Moore decode of the outputs from registered state only.
   always_comb begin
      bus.y         = '0;
      bus.active_ch = '0;
      if (state == S_RUN) begin
         bus.y         = YW'(int'(ch) * STEPS + int'(step) + 1);
         bus.active_ch = ch;
      end
      bus.busy = (bus.y != '0);
      bus.done = done_q;
   end
endmodule

// File: tb/tb_seq_light_n.sv
// Directed bench for seq_light_n with NCH=3, STEPS=3, DW=4.
module tb_seq_light_n;
   logic clk;
   logic reset;
   int   tests;
   int   failed;

   seq_light_n_if #(.NCH(3), .STEPS(3), .DW(4)) bus ();

   seq_light_n #(.NCH(3), .STEPS(3), .DW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_y(input string tag, input int exp_y, input int exp_done);
      check({tag, "_y"}, 32'(bus.y), 32'(exp_y));
      check({tag, "_busy"}, 32'(bus.busy), (exp_y != 0) ? 32'd1 : 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
   endtask

   initial begin
      int exp_a[$];
      tests         = 0;
      failed        = 0;
      reset         = 1'b0;
      bus.req       = '0;
      bus.dwell     = '0;
      bus.repeat_en = 1'b0;
      bus.abort     = 1'b0;
      tick();
      tick();
      check_y("rst", 0, 0);
      check("rst_ach", 32'(bus.active_ch), 32'd0);
      reset = 1'b1;
      tick();
      check_y("post_rst_idle", 0, 0);

      // Single pulse on channel 0, dwell 0.
      bus.req = 3'b001;
      tick();
      bus.req = 3'b000;
      check_y("c0_s0", 1, 0);
      check("c0_ach", 32'(bus.active_ch), 32'd0);
      tick(); check_y("c0_s1", 2, 0);
      tick(); check_y("c0_s2", 3, 0);
      tick(); check_y("c0_end", 0, 1);
      tick(); check_y("c0_idle", 0, 0);

      // Channels 1 and 2 held with no repeat. Channel 2 wins and idles one cycle between runs.
      bus.req = 3'b110;
      exp_a = '{7, 8, 9, 0, 7, 8, 9, 0};
      for (int i = 0; i < 8; i++) begin
         tick();
         check_y($sformatf("c2_hold_%0d", i), exp_a[i], (exp_a[i] == 0) ? 1 : 0);
         if (exp_a[i] != 0) check($sformatf("c2_ach_%0d", i), 32'(bus.active_ch), 32'd2);
      end
      bus.req = 3'b000;
      tick(); check_y("c2_idle", 0, 0);

      // Dwell 2 on channel 1. A dwell change mid-run must not affect the running sequence.
      bus.dwell = 4'd2;
      bus.req   = 3'b010;
      exp_a = '{4, 4, 4, 5, 5, 5, 6, 6, 6, 0};
      for (int i = 0; i < 10; i++) begin
         tick();
         bus.req = 3'b000;
         if (i == 1) bus.dwell = 4'd0;
         check_y($sformatf("dw2_%0d", i), exp_a[i], (i == 9) ? 1 : 0);
      end
      tick(); check_y("dw2_idle", 0, 0);

      // Repeat on channel 0 restarts with no gap, and done pulses on each restart.
      bus.dwell     = 4'd0;
      bus.repeat_en = 1'b1;
      bus.req       = 3'b001;
      exp_a = '{1, 2, 3, 1, 2, 3};
      for (int i = 0; i < 6; i++) begin
         tick();
         check_y($sformatf("rep_%0d", i), exp_a[i], (i == 3) ? 1 : 0);
      end
      bus.req = 3'b000;
      tick(); check_y("rep_end", 0, 1);
      bus.repeat_en = 1'b0;
      tick(); check_y("rep_idle", 0, 0);

      // Abort during step 2 returns to idle with no done pulse.
      bus.req = 3'b001;
      tick(); bus.req = 3'b000; check_y("ab_s0", 1, 0);
      tick(); check_y("ab_s1", 2, 0);
      bus.abort = 1'b1;
      tick(); bus.abort = 1'b0; check_y("ab_cut", 0, 0);
      tick(); check_y("ab_idle", 0, 0);

      // Abort in idle has no effect. Channel 2 waits for channel 0 to finish, then one idle cycle.
      bus.abort = 1'b1;
      bus.req   = 3'b001;
      tick();
      bus.abort = 1'b0;
      bus.req   = 3'b100;
      check_y("np_c0s0", 1, 0);
      tick(); check_y("np_c0s1", 2, 0);
      tick(); check_y("np_c0s2", 3, 0);
      tick(); check_y("np_gap", 0, 1);
      tick(); check_y("np_c2s0", 7, 0);
      check("np_ach", 32'(bus.active_ch), 32'd2);
      bus.req = 3'b000;
      tick(); check_y("np_c2s1", 8, 0);
      tick(); check_y("np_c2s2", 9, 0);
      tick(); check_y("np_end", 0, 1);

      // Asynchronous reset mid-sequence.
      bus.req = 3'b010;
      tick(); bus.req = 3'b000; check_y("ar_s0", 4, 0);
      tick(); check_y("ar_s1", 5, 0);
      #2;
      reset = 1'b0;
      #1;
      check_y("ar_async", 0, 0);
      check("ar_ach", 32'(bus.active_ch), 32'd0);
      #1;
      reset = 1'b1;
      tick(); check_y("ar_rel_idle0", 0, 0);
      tick(); check_y("ar_rel_idle1", 0, 0);

      // The first edge after reset release samples req.
      reset   = 1'b0;
      bus.req = 3'b100;
      #2;
      reset = 1'b1;
      tick();
      bus.req = 3'b000;
      check_y("rr_s0", 7, 0);
      tick(); check_y("rr_s1", 8, 0);
      tick(); check_y("rr_s2", 9, 0);
      tick(); check_y("rr_end", 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/seq_light_n.md
SEQ_LIGHT_N -- requirements
Module: seq_light_n

Interface
REQ-001 Parameter NCH, default 3, number of request channels (1..8).
REQ-002 Parameter STEPS, default 3, steps per channel sequence (1..16).
REQ-003 Parameter DW, default 4, width of dwell value.
REQ-004 Derived YW = $clog2(NCH*STEPS+1), width of step code output.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-007 req  input  NCH  per-channel sequence request, level-sensitive, higher index = higher priority.
REQ-008 dwell  input  DW  step hold length minus one; step lasts dwell+1 cycles.
REQ-009 repeat_en  input  1  when high, a channel whose req is still high restarts without passing through idle.
REQ-010 abort  input  1  synchronous abort of the running sequence.
REQ-011 y  output  YW  step code; 0 = idle, else k*STEPS+s+1 for channel k, step s.
REQ-012 busy  output  1  high whenever y != 0.
REQ-013 active_ch  output  $clog2(NCH) (min 1)  channel currently running; 0 when idle.
REQ-014 done  output  1  one-cycle pulse on normal completion of a sequence.

Function
REQ-015 FSM states: IDLE, RUN; RUN carries registers ch (channel), step (0..STEPS-1), cnt (DW bits), dw_lat (latched dwell).
REQ-016 y, busy, active_ch shall be decoded from state registers only (Moore); no combinational path from any input to y.
REQ-017 IDLE, req==0: remain IDLE, y=0.
REQ-018 IDLE, req!=0: next cycle RUN with ch = highest set index, step=0, cnt=0, dw_lat=dwell; latency one clock from req sampled to y != 0.
REQ-019 RUN: cnt increments each cycle; when cnt==dw_lat, cnt clears and step advances.
REQ-020 dwell changes during RUN shall have no effect until the next sequence start or restart.
REQ-021 Last step (step==STEPS-1, cnt==dw_lat): if repeat_en and req[ch] high, restart same ch at step 0 next cycle, dw_lat reloaded from dwell; else go IDLE.
REQ-022 Requests on other channels during RUN are ignored (no preemption); a pending higher-priority req is served from IDLE after completion.
REQ-023 After non-repeating completion, IDLE lasts at least one cycle (y=0) before a new sequence starts.
REQ-024 done shall be high for exactly the one cycle following the final cycle of the last step, for both IDLE return and repeat restart.
REQ-025 abort high in RUN: next cycle IDLE, y=0, done stays 0; abort in IDLE has no effect; abort takes precedence over step advance and repeat.
REQ-026 req deassertion mid-sequence shall not shorten the sequence.
REQ-027 STEPS=1: each sequence is a single step of dwell+1 cycles.
REQ-028 Illegal/unreachable encodings of step or ch shall return to IDLE next cycle with y=0.

Reset
REQ-029 reset low: state=IDLE, ch=0, step=0, cnt=0, dw_lat=0, y=0, busy=0, active_ch=0, done=0, asynchronously.
REQ-030 reset deasserted: first edge samples req as in REQ-018; reset mid-sequence abandons it with no done pulse.

Verification (NCH=3, STEPS=3, DW=4 unless stated)
REQ-031 dwell=0, req=3'b001 one cycle -> y = 1,2,3 on successive cycles, then 0; done high in the cycle y returns to 0.
REQ-032 dwell=0, req=3'b110 held, repeat_en=0 -> y = 7,8,9,0,7,8,9,0...; active_ch=2 while busy.
REQ-033 dwell=2, req=3'b010 pulse -> y = 4,4,4,5,5,5,6,6,6,0; dwell changed to 0 mid-run has no effect.
REQ-034 dwell=0, repeat_en=1, req=3'b001 held -> y = 1,2,3,1,2,3 with no 0 gap; done pulses each cycle y returns to 1.
REQ-035 req=3'b001 then abort during y=2 -> next y=0, done=0; req=3'b100 asserted during ch0 run -> served only after ch0 completes and one idle cycle.
REQ-036 reset driven low while y=5 -> y=0, busy=0 immediately without a clock edge; release with req=0 -> stays IDLE.
